dmem_share_ctrl: RTL and testbench
==================================

Name: dmem_share_ctrl

Overview:
Parametrised data-memory sharing controller placed between rv32i_core's data port, ram_wrap and seg7_ctrl. It replaces the fixed run/display mux with time-shared access. The core keeps the RAM in run mode. A scan engine periodically reads N_DISP display words from DISP_BASE into shadow registers, so the display refreshes while the program runs. In display mode the core is stalled and scanning is continuous.

Parameters:
AW, 32, address width
DW, 32, data width; byte-lane count BE = DW/8
N_DISP, 2, number of consecutive display words captured (>=1)
DISP_BASE, 32'h200, byte address of display word 0; word i at DISP_BASE + i*(DW/8)
SCAN_DIV, 1024, cycles between scan-burst starts in run mode (>=N_DISP*(RD_LAT+1))
RD_LAT, 1, RAM read latency in cycles (>=1)

Ports:
m_clock  in  1  clock
rst_n  in  1  reset
mode_in  in  1  asynchronous MODE switch (1 = display mode)
core_r  in  1  core read request, held until core_ready
core_w  in  1  core write request, held until core_ready
core_addr  in  AW  core byte address
core_wdata  in  DW  core write data
core_be  in  BE  core byte enables
core_rdata  out  DW  read data, valid when core_ready=1 for a read
core_ready  out  1  one-cycle completion strobe
ram_addr  out  AW  RAM address
ram_wdata  out  DW  RAM write data
ram_rden  out  BE  RAM byte read enables
ram_wren  out  BE  RAM byte write enables
ram_rdata  in  DW  RAM read data, RD_LAT cycles after rden
disp_data  out  N_DISP*DW  shadow words; word i in bits [i*DW +: DW]
disp_valid  out  1  sticky; set when the first full scan burst completes
mode_sync  out  1  synchronised mode

Behaviour:
- Reset is asynchronous and active-low (rst_n); the clock is m_clock.
- Reset values:
  - all ram_* outputs 0, core_ready 0, core_rdata 0
  - disp_data 0, disp_valid 0, mode_sync 0
  - FSM in IDLE, scan index 0, scan_pend 0, scan timer SCAN_DIV-1
- mode_sync: two-flop synchroniser of mode_in. Its value is acted on only in IDLE.
- Scan timer (runs in both modes):
  - Decrements every cycle.
  - At 0 it reloads SCAN_DIV-1 and sets scan_pend.
  - In display mode scan_pend is forced to 1.
- FSM states: IDLE, CORE_RD, SCAN_RD.
- IDLE, priority order:
  1. Core write: if mode_sync=0 and core_w. Drive ram_addr=core_addr, ram_wdata=core_wdata, ram_wren=core_be combinationally; core_ready=1 in the same cycle; stay in IDLE.
  2. Core read: if mode_sync=0 and core_r. Drive ram_addr=core_addr, ram_rden=core_be; go to CORE_RD with latency counter RD_LAT-1.
  3. Scan read: if scan_pend. Drive ram_addr=DISP_BASE+idx*(DW/8), ram_rden=all ones; go to SCAN_RD.
  4. Otherwise all enables are 0.
- core_r and core_w together: write wins. Read stays pending and is served at the next IDLE.
- CORE_RD:
  - Enables are 0.
  - When the counter reaches 0 (RD_LAT cycles after issue): core_ready=1, core_rdata=ram_rdata; return to IDLE.
  - core_rdata holds its last value otherwise.
- SCAN_RD, after RD_LAT cycles:
  - Latch ram_rdata into disp_data word idx.
  - If idx=N_DISP-1: idx wraps to 0, clear scan_pend, set disp_valid.
  - Else idx+1.
  - Return to IDLE.
- A burst may be interleaved with core accesses between words; a word read is never aborted. Bus idle for one cycle between every transaction (IDLE slot).
- Display mode: core_ready stays 0, so core requests are held. A mode change during CORE_RD or SCAN_RD takes effect at the next IDLE.
- Address arithmetic is modulo 2^AW; no bounds check.
- Async reset mid-transaction drops it. No core_ready is issued for it, and ram enables drop immediately.

Decomposition:
- Package dmem_share_pkg:
  - FSM state encoding (IDLE/CORE_RD/SCAN_RD)
  - BE derivation helper
  - default DISP_BASE constant
- One sub-module: sync2 (parametrised-width two-flop synchroniser, reset 0), used for mode_in.

Test Plan:
- Reset: rst_n low mid-CORE_RD -> ram_rden=0 and core_ready=0 immediately. After release, disp_valid=0 and disp_data=0.
- Core write: mode_in=0, core_w with addr 0x40, wdata 0x12345678, be 4'hF -> same cycle ram_wren=4'hF, ram_addr=0x40, core_ready=1.
- Core read: RD_LAT=2, core_r at 0x44, RAM returns 0xDEADBEEF -> core_ready=1 exactly 2 cycles after issue with core_rdata=0xDEADBEEF.
- Scan burst: SCAN_DIV=16, N_DISP=2, RAM[0x200]=0x11, RAM[0x204]=0x22 -> disp_data={0x22,0x11}, disp_valid=1 after first burst.
- Contention: core_r held continuously while scan_pend -> core and scan alternate, and the burst finishes within N_DISP*2*(RD_LAT+2) cycles.
- Mode switch: mode_in=1 during core read -> read completes with core_ready. Subsequent core_w is stalled (core_ready=0) while scan reads repeat back-to-back. mode_in=0 -> stalled write completes.

Source files
------------

// File: rtl/dmem_share_pkg.sv
// Shared types and helpers for the data-memory sharing controller.
package dmem_share_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        SCAN_RD = 2'd2
    } state_t;

    localparam logic [31:0] DISP_BASE_DEFAULT = 32'h0000_0200;

    function automatic int unsigned be_count(input int unsigned dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/dmem_share_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, clears to 0 on reset.
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         m_clock,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dmem_share_ctrl.sv
// Time-shares one RAM port between the core data port and a display scan
// engine that keeps N_DISP shadow words refreshed from DISP_BASE.
module dmem_share_ctrl
    import dmem_share_pkg::*;
#(
    parameter int unsigned   AW        = 32,
    parameter int unsigned   DW        = 32,
    parameter int unsigned   N_DISP    = 2,
    parameter logic [AW-1:0] DISP_BASE = AW'(DISP_BASE_DEFAULT),
    parameter int unsigned   SCAN_DIV  = 1024,
    parameter int unsigned   RD_LAT    = 1,
    localparam int unsigned  BE        = be_count(DW)
) (
    input  logic               m_clock,
    input  logic               rst_n,
    input  logic               mode_in,
    input  logic               core_r,
    input  logic               core_w,
    input  logic [AW-1:0]      core_addr,
    input  logic [DW-1:0]      core_wdata,
    input  logic [BE-1:0]      core_be,
    output logic [DW-1:0]      core_rdata,
    output logic               core_ready,
    output logic [AW-1:0]      ram_addr,
    output logic [DW-1:0]      ram_wdata,
    output logic [BE-1:0]      ram_rden,
    output logic [BE-1:0]      ram_wren,
    input  logic [DW-1:0]      ram_rdata,
    output logic [N_DISP*DW-1:0] disp_data,
    output logic               disp_valid,
    output logic               mode_sync
);

    localparam int unsigned IDXW = (N_DISP > 1) ? $clog2(N_DISP) : 1;
    localparam int unsigned LW   = $clog2(RD_LAT + 1);
    localparam int unsigned TW   = $clog2(SCAN_DIV + 1);

    state_t          state_q, state_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [IDXW-1:0] idx_q;
    logic            scan_pend_q;
    logic [TW-1:0]   timer_q;
    logic            scan_prio_q;
    logic [DW-1:0]   rdata_q;
    logic [DW-1:0]   disp_q [N_DISP];
    logic [AW-1:0]   scan_addr;
    logic            lat_done;
    logic            scan_done;
    logic            last_word;
    logic            grant_core_rd;
    logic            grant_scan;

    sync2 #(.W(1)) u_mode_sync (
        .m_clock (m_clock),
        .rst_n   (rst_n),
        .d       (mode_in),
        .q       (mode_sync)
    );

    assign lat_done  = (lat_q == '0);
    assign scan_done = (state_q == SCAN_RD) && lat_done;
    assign last_word = (idx_q == IDXW'(N_DISP - 1));
    assign scan_addr = DISP_BASE + AW'(idx_q) * AW'(DW / 8);

    always_comb begin
        state_d       = state_q;
        lat_d         = lat_q;
        ram_addr      = '0;
        ram_wdata     = '0;
        ram_rden      = '0;
        ram_wren      = '0;
        core_ready    = 1'b0;
        core_rdata    = rdata_q;
        grant_core_rd = 1'b0;
        grant_scan    = 1'b0;
        case (state_q)
            IDLE: begin
                // A core read just served yields the next slot to a pending
                // scan, so a continuously held read cannot starve the display.
                if (!mode_sync && core_w) begin
                    ram_addr   = core_addr;
                    ram_wdata  = core_wdata;
                    ram_wren   = core_be;
                    core_ready = 1'b1;
                end else if (!mode_sync && core_r && !(scan_pend_q && scan_prio_q)) begin
                    ram_addr      = core_addr;
                    ram_rden      = core_be;
                    grant_core_rd = 1'b1;
                    state_d       = CORE_RD;
                    lat_d         = LW'(RD_LAT - 1);
                end else if (scan_pend_q) begin
                    ram_addr   = scan_addr;
                    ram_rden   = '1;
                    grant_scan = 1'b1;
                    state_d    = SCAN_RD;
                    lat_d      = LW'(RD_LAT - 1);
                end
            end
            CORE_RD: begin
                if (lat_done) begin
                    core_ready = 1'b1;
                    core_rdata = ram_rdata;
                    state_d    = IDLE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            SCAN_RD: begin
                if (lat_done) begin
                    state_d = IDLE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs drop with reset itself, not at the next clock edge.
        if (!rst_n) begin
            ram_rden   = '0;
            ram_wren   = '0;
            core_ready = 1'b0;
        end
    end

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            scan_prio_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (grant_core_rd) begin
                scan_prio_q <= 1'b1;
            end else if (grant_scan) begin
                scan_prio_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= TW'(SCAN_DIV - 1);
            scan_pend_q <= 1'b0;
        end else begin
            if (timer_q == '0) begin
                timer_q <= TW'(SCAN_DIV - 1);
            end else begin
                timer_q <= timer_q - 1'b1;
            end
            if (scan_done && last_word) begin
                scan_pend_q <= 1'b0;
            end
            if (timer_q == '0 || mode_sync) begin
                scan_pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state_q == CORE_RD && lat_done) begin
            rdata_q <= ram_rdata;
        end
    end

    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= '0;
            disp_valid <= 1'b0;
            for (int unsigned i = 0; i < N_DISP; i++) begin
                disp_q[i] <= '0;
            end
        end else if (scan_done) begin
            disp_q[idx_q] <= ram_rdata;
            if (last_word) begin
                idx_q      <= '0;
                disp_valid <= 1'b1;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_DISP; g++) begin : g_disp
        assign disp_data[g*DW +: DW] = disp_q[g];
    end

endmodule

// File: tb/tb_dmem_share_ctrl.sv
// Self-checking bench for dmem_share_ctrl with a latency-accurate RAM model.
module tb_dmem_share_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned ND = 2;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned SDIV = 16;

    logic m_clock = 1'b0;
    logic rst_n = 1'b0;
    logic mode_in = 1'b0;
    logic core_r = 1'b0;
    logic core_w = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [3:0] core_be = '0;
    logic [DW-1:0] core_rdata;
    logic core_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [3:0] ram_rden;
    logic [3:0] ram_wren;
    logic [DW-1:0] ram_rdata;
    logic [ND*DW-1:0] disp_data;
    logic disp_valid;
    logic mode_sync;

    logic poke_en = 1'b0;
    logic [31:0] poke_addr = '0;
    logic [31:0] poke_data = '0;
    logic [31:0] mem [0:255];
    logic [31:0] pipe [RD_LAT];

    int n_checks = 0;
    int n_err = 0;
    logic [31:0] sb [$];

    always #5 m_clock = ~m_clock;

    dmem_share_ctrl #(
        .AW(AW), .DW(DW), .N_DISP(ND), .DISP_BASE(32'h200),
        .SCAN_DIV(SDIV), .RD_LAT(RD_LAT)
    ) dut (
        .m_clock(m_clock), .rst_n(rst_n), .mode_in(mode_in),
        .core_r(core_r), .core_w(core_w), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_be(core_be),
        .core_rdata(core_rdata), .core_ready(core_ready),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rden(ram_rden),
        .ram_wren(ram_wren), .ram_rdata(ram_rdata),
        .disp_data(disp_data), .disp_valid(disp_valid), .mode_sync(mode_sync)
    );

    always @(posedge m_clock) begin
        if (poke_en) begin
            mem[poke_addr[9:2]] <= poke_data;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wren[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
        pipe[0] <= mem[ram_addr[9:2]];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdata = pipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(posedge m_clock); #1;
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(posedge m_clock); #1;
        poke_en = 1'b0;
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input logic [31:0] ex, input string nm);
        bit issued = 0;
        bit done = 0;
        int ic = 0;
        logic [31:0] e;
        @(posedge m_clock); #1;
        core_addr = a; core_wdata = wd; core_be = be; core_w = wr; core_r = !wr;
        if (!wr) sb.push_back(ex);
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge m_clock);
            if (!wr && !issued && ram_rden == be && ram_addr == a) begin
                issued = 1; ic = c;
            end
            if (core_ready) begin
                done = 1;
                if (wr) begin
                    chk({nm, "_wren"}, {60'd0, ram_wren}, {60'd0, be});
                    chk({nm, "_waddr"}, {32'd0, ram_addr}, {32'd0, a});
                    chk({nm, "_wdata"}, {32'd0, ram_wdata}, {32'd0, wd});
                end else begin
                    e = sb.pop_front();
                    chk({nm, "_lat"}, issued ? 64'(c - ic) : 64'hFFFF, 64'(RD_LAT));
                    chk({nm, "_rdata"}, {32'd0, core_rdata}, {32'd0, e});
                end
            end
        end
        if (!done) begin
            fail_to(nm);
            if (!wr) void'(sb.pop_front());
        end
        @(posedge m_clock); #1;
        core_w = 1'b0; core_r = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vec [8];

    initial begin
        int s0, w1, nrdy, nscan, nbad;
        bit done;

        vec[0] = '{1, 32'h40,  32'h12345678, 4'hF,    32'h0};
        vec[1] = '{0, 32'h40,  32'h0,        4'hF,    32'h12345678};
        vec[2] = '{1, 32'h40,  32'hAABBCCDD, 4'b0011, 32'h0};
        vec[3] = '{0, 32'h40,  32'h0,        4'hF,    32'h1234CCDD};
        vec[4] = '{0, 32'h44,  32'h0,        4'hF,    32'hDEADBEEF};
        vec[5] = '{1, 32'h4C,  32'hFFEEDDCC, 4'b1010, 32'h0};
        vec[6] = '{0, 32'h4C,  32'h0,        4'hF,    32'hFF02DD04};
        vec[7] = '{0, 32'h200, 32'h0,        4'h3,    32'h00000011};

        poke(32'h44, 32'hDEADBEEF);
        poke(32'h4C, 32'h01020304);
        poke(32'h200, 32'h11);
        poke(32'h204, 32'h22);
        @(posedge m_clock); #1;
        rst_n = 1'b1;
        @(negedge m_clock);
        chk("rst_disp_valid", {63'd0, disp_valid}, 64'd0);
        chk("rst_disp_data", disp_data, 64'd0);
        chk("rst_core_ready", {63'd0, core_ready}, 64'd0);
        chk("rst_rden", {60'd0, ram_rden}, 64'd0);
        chk("rst_core_rdata", {32'd0, core_rdata}, 64'd0);
        chk("rst_mode_sync", {63'd0, mode_sync}, 64'd0);

        done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge m_clock);
            if (disp_valid) done = 1;
        end
        if (!done) fail_to("scan_first_burst");
        chk("scan_disp_data", disp_data, {32'h22, 32'h11});

        for (int i = 0; i < 8; i++) begin
            run_txn(vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].be, vec[i].exp,
                    $sformatf("vec%0d", i));
        end

        // Write and read requested together: write first, read afterwards.
        @(posedge m_clock); #1;
        core_addr = 32'h50; core_wdata = 32'h5A5A0055; core_be = 4'hF;
        core_w = 1'b1; core_r = 1'b1;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge m_clock);
            if (core_ready) begin
                done = 1;
                chk("both_write_wins", {60'd0, ram_wren}, 64'hF);
            end
        end
        if (!done) fail_to("both_write");
        run_txn(0, 32'h50, 32'h0, 4'hF, 32'h5A5A0055, "both_read");

        // Contention: core read held continuously against a scan burst.
        poke(32'h200, 32'h33);
        poke(32'h204, 32'h44);
        @(posedge m_clock); #1;
        core_addr = 32'h44; core_be = 4'hF; core_r = 1'b1;
        s0 = -1; w1 = -1; nrdy = 0; done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge m_clock);
            if (s0 < 0 && ram_rden == 4'hF && ram_addr == 32'h200) s0 = c;
            if (s0 >= 0 && w1 < 0 && ram_rden == 4'hF && ram_addr == 32'h204) w1 = c;
            if (core_ready) begin
                chk("cont_rdata", {32'd0, core_rdata}, {32'd0, 32'hDEADBEEF});
                if (s0 >= 0 && w1 < 0) nrdy++;
            end
            if (w1 >= 0 && c == w1 + int'(RD_LAT) + 1) begin
                done = 1;
                chk("cont_disp_data", disp_data, {32'h44, 32'h33});
                chk("cont_within_bound", {63'd0, (c - s0) <= int'(ND * 2 * (RD_LAT + 2))}, 64'd1);
                chk("cont_core_between", {63'd0, nrdy >= 1}, 64'd1);
            end
        end
        if (!done) fail_to("contention");
        @(posedge m_clock); #1;
        core_r = 1'b0;

        // Mode switch during a core read; then a write is held off in display mode.
        @(posedge m_clock); #1;
        core_addr = 32'h44; core_be = 4'hF; core_r = 1'b1;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge m_clock);
            if (ram_rden == 4'hF && ram_addr == 32'h44) done = 1;
        end
        if (!done) fail_to("mode_rd_issue");
        @(posedge m_clock); #1;
        mode_in = 1'b1;
        done = 0;
        for (int c = 0; c < 10 && !done; c++) begin
            if (c > 0) @(negedge m_clock);
            else #1;
            if (core_ready) begin
                done = 1;
                chk("mode_rd_rdata", {32'd0, core_rdata}, {32'd0, 32'hDEADBEEF});
            end
        end
        if (!done) fail_to("mode_rd_ready");
        @(posedge m_clock); #1;
        core_r = 1'b0;
        done = 0;
        for (int c = 0; c < 6 && !done; c++) begin
            @(negedge m_clock);
            if (mode_sync) done = 1;
        end
        chk("mode_sync_high", {63'd0, mode_sync}, 64'd1);
        @(posedge m_clock); #1;
        core_addr = 32'h48; core_wdata = 32'hCAFEF00D; core_be = 4'hF; core_w = 1'b1;
        nscan = 0; nbad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge m_clock);
            if (core_ready || ram_wren != 4'h0) nbad++;
            if (ram_rden == 4'hF && (ram_addr == 32'h200 || ram_addr == 32'h204)) nscan++;
        end
        chk("disp_mode_stall", 64'(nbad), 64'd0);
        chk("disp_mode_scans", {63'd0, nscan >= 8}, 64'd1);
        @(posedge m_clock); #1;
        mode_in = 1'b0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge m_clock);
            if (core_ready) begin
                done = 1;
                chk("mode_w_wren", {60'd0, ram_wren}, 64'hF);
                chk("mode_w_addr", {32'd0, ram_addr}, 64'h48);
            end
        end
        if (!done) fail_to("mode_w_release");
        @(posedge m_clock); #1;
        core_w = 1'b0;
        run_txn(0, 32'h48, 32'h0, 4'hF, 32'hCAFEF00D, "mode_w_readback");

        // Reset in the middle of a core read.
        @(posedge m_clock); #1;
        core_addr = 32'h44; core_be = 4'hF; core_r = 1'b1;
        done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge m_clock);
            if (ram_rden == 4'hF && ram_addr == 32'h44) done = 1;
        end
        if (!done) fail_to("rst_rd_issue");
        @(posedge m_clock); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rden", {60'd0, ram_rden}, 64'd0);
        chk("midrst_ready", {63'd0, core_ready}, 64'd0);
        @(posedge m_clock); #1;
        core_r = 1'b0;
        @(posedge m_clock); #1;
        rst_n = 1'b1;
        @(negedge m_clock);
        chk("post_rst_valid", {63'd0, disp_valid}, 64'd0);
        chk("post_rst_disp", disp_data, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
